// File: rtl/serv_bufreg3.sv
// Bit-serial buffer register: store aligner, load capture/extend/serialiser, shift-amount downcounter.
// Optional build macro SERV_BUFREG_MISALIGN_TRAP_EN turns misaligned load/store into a trap instead of a bus access.
module serv_bufreg3 #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int LB             = $clog2(BITS_PER_CYCLE),
    parameter int SHW            = $clog2(XLEN)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [1:0]                i_mode,
    input  logic                      i_en,
    input  logic                      i_op_b_sel,
    input  logic [BITS_PER_CYCLE-1:0] i_rs2,
    input  logic [BITS_PER_CYCLE-1:0] i_imm,
    input  logic [SHW-4:0]            i_lsb,
    input  logic [1:0]                i_size,
    input  logic                      i_signed,
    input  logic                      i_ack,
    input  logic [XLEN-1:0]           i_rdt,
    output logic [BITS_PER_CYCLE-1:0] o_op_b,
    output logic                      o_req,
    output logic [XLEN-1:0]           o_dat,
    output logic [XLEN/8-1:0]         o_sel,
    output logic [BITS_PER_CYCLE-1:0] o_q,
    output logic                      o_sh_done,
    output logic [LB:0]               o_sh_rem,
    output logic                      o_done,
    output logic                      o_misalign,
    output logic                      o_busy
);

    localparam int N    = XLEN / BITS_PER_CYCLE;
    localparam int NB   = XLEN / 8;
    localparam int LSBW = SHW - 3;

    typedef enum logic [2:0] {IDLE, FILL, WAIT, COUNT, DRAIN} state_t;
    typedef enum logic [1:0] {M_STORE = 2'd0, M_LOAD = 2'd1, M_SHIFT = 2'd2} mode_t;

    state_t          state_q, state_d;
    mode_t           mode_q, mode_d;
    logic [XLEN-1:0] dat_q, dat_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [LSBW-1:0] lsb_q, lsb_d;
    logic [1:0]      size_q, size_d;
    logic            signed_q, signed_d;

    logic            done, sh_done, misalign;
    logic            last_beat;
    logic [SHW-1:0]  shamt;
    logic            store_out;
    logic [XLEN-1:0] rdt_sh, keep, ld_ext;
    logic            sbit;
    logic [NB-1:0]   sel_base;

    assign o_op_b    = i_op_b_sel ? i_rs2 : i_imm;
    assign last_beat = (cnt_q == SHW'(N - 1));
    assign shamt     = dat_q[SHW-1:0];

`ifdef SERV_BUFREG_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (lsb_q & LSBW'((4'd1 << size_q) - 4'd1)) != '0;
`endif

    // Load data: shift the addressed bytes down, keep the accessed width, then extend.
    always_comb begin
        rdt_sh = i_rdt >> {lsb_q, 3'b000};
        case (size_q)
            2'd0:    begin keep = XLEN'(8'hFF);         sbit = rdt_sh[7];      end
            2'd1:    begin keep = XLEN'(16'hFFFF);      sbit = rdt_sh[15];     end
            2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sbit = rdt_sh[31];     end
            default: begin keep = '1;                   sbit = rdt_sh[XLEN-1]; end
        endcase
        ld_ext = (rdt_sh & keep) | ((signed_q && sbit) ? ~keep : '0);
    end

    always_comb begin
        case (size_q)
            2'd0:    sel_base = NB'(1);
            2'd1:    sel_base = NB'(3);
            2'd2:    sel_base = NB'(15);
            default: sel_base = '1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dat_d    = dat_q;
        cnt_d    = cnt_q;
        lsb_d    = lsb_q;
        size_d   = size_q;
        signed_d = signed_q;
        done     = 1'b0;
        sh_done  = 1'b0;
        misalign = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    // Reserved mode 3 collapses onto store here so later states never see it.
                    mode_d   = (i_mode == 2'd2) ? M_SHIFT : (i_mode == 2'd1) ? M_LOAD : M_STORE;
                    lsb_d    = i_lsb;
                    size_d   = i_size;
                    signed_d = i_signed;
                    cnt_d    = '0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (i_en) begin
                    dat_d = {o_op_b, dat_q[XLEN-1:BITS_PER_CYCLE]};
                    cnt_d = cnt_q + SHW'(1);
                    if (last_beat) begin
                        cnt_d = '0;
                        if (mode_q == M_SHIFT) begin
                            state_d = COUNT;
                        end
`ifdef SERV_BUFREG_MISALIGN_TRAP_EN
                        else if (misaligned) begin
                            state_d  = IDLE;
                            done     = 1'b1;
                            misalign = 1'b1;
                        end
`endif
                        else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (i_ack) begin
                    if (mode_q == M_LOAD) begin
                        dat_d   = ld_ext;
                        state_d = DRAIN;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COUNT: begin
                if (shamt >= SHW'(BITS_PER_CYCLE)) begin
                    dat_d[SHW-1:0] = shamt - SHW'(BITS_PER_CYCLE);
                end else begin
                    sh_done = 1'b1;
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (i_en) begin
                    dat_d = dat_q >> BITS_PER_CYCLE;
                    cnt_d = cnt_q + SHW'(1);
                    if (last_beat) begin
                        cnt_d   = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            mode_q   <= M_STORE;
            dat_q    <= '0;
            cnt_q    <= '0;
            lsb_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dat_q    <= dat_d;
            cnt_q    <= cnt_d;
            lsb_q    <= lsb_d;
            size_q   <= size_d;
            signed_q <= signed_d;
        end
    end

    assign store_out  = (state_q == WAIT) && (mode_q == M_STORE);
    assign o_req      = (state_q == WAIT);
    assign o_busy     = (state_q != IDLE);
    assign o_dat      = store_out ? (dat_q << {lsb_q, 3'b000}) : '0;
    assign o_sel      = store_out ? NB'(sel_base << lsb_q) : '0;
    assign o_q        = (state_q == DRAIN) ? dat_q[BITS_PER_CYCLE-1:0] : '0;
    assign o_sh_done  = sh_done;
    assign o_sh_rem   = sh_done ? shamt[LB:0] : '0;
    assign o_done     = done;
    assign o_misalign = misalign;

endmodule

// File: tb/tb_serv_bufreg3.sv
// Bench for serv_bufreg3: a 32-bit/1-bit and a 64-bit/4-bit instance checked against an arithmetic model.
module tb_serv_bufreg3;

`ifdef SERV_BUFREG_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  mode = '0;
    logic        en = 1'b0, op_b_sel = 1'b0;
    logic [3:0]  rs2 = '0, imm = '0;
    logic [2:0]  lsb = '0;
    logic [1:0]  size = '0;
    logic        sgn = 1'b0, ack = 1'b0;
    logic [63:0] rdt = '0;

    logic [0:0]  op_b_a, q_a, sh_rem_a;
    logic        req_a, sh_done_a, done_a, mis_a, busy_a;
    logic [31:0] dat_a;
    logic [3:0]  sel_a;
    logic [3:0]  op_b_b, q_b;
    logic [2:0]  sh_rem_b;
    logic        req_b, sh_done_b, done_b, mis_b, busy_b;
    logic [63:0] dat_b;
    logic [7:0]  sel_b;

    int checks = 0;
    int errors = 0;
    bit inst = 1'b0;
    int gap_mode = 0;
    bit gap_tog = 1'b0;

    always #5 clk = ~clk;

    serv_bufreg3 #(.XLEN(32), .BITS_PER_CYCLE(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_mode(mode), .i_en(en),
        .i_op_b_sel(op_b_sel), .i_rs2(rs2[0:0]), .i_imm(imm[0:0]), .i_lsb(lsb[1:0]),
        .i_size(size), .i_signed(sgn), .i_ack(ack), .i_rdt(rdt[31:0]),
        .o_op_b(op_b_a), .o_req(req_a), .o_dat(dat_a), .o_sel(sel_a), .o_q(q_a),
        .o_sh_done(sh_done_a), .o_sh_rem(sh_rem_a), .o_done(done_a),
        .o_misalign(mis_a), .o_busy(busy_a));

    serv_bufreg3 #(.XLEN(64), .BITS_PER_CYCLE(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_mode(mode), .i_en(en),
        .i_op_b_sel(op_b_sel), .i_rs2(rs2), .i_imm(imm), .i_lsb(lsb),
        .i_size(size), .i_signed(sgn), .i_ack(ack), .i_rdt(rdt),
        .o_op_b(op_b_b), .o_req(req_b), .o_dat(dat_b), .o_sel(sel_b), .o_q(q_b),
        .o_sh_done(sh_done_b), .o_sh_rem(sh_rem_b), .o_done(done_b),
        .o_misalign(mis_b), .o_busy(busy_b));

    logic [63:0] m_op_b, m_dat, m_sel, m_q, m_sh_rem;
    logic        m_req, m_sh_done, m_done, m_mis, m_busy;
    assign m_op_b    = inst ? 64'(op_b_b)   : 64'(op_b_a);
    assign m_dat     = inst ? dat_b         : 64'(dat_a);
    assign m_sel     = inst ? 64'(sel_b)    : 64'(sel_a);
    assign m_q       = inst ? 64'(q_b)      : 64'(q_a);
    assign m_sh_rem  = inst ? 64'(sh_rem_b) : 64'(sh_rem_a);
    assign m_req     = inst ? req_b     : req_a;
    assign m_sh_done = inst ? sh_done_b : sh_done_a;
    assign m_done    = inst ? done_b    : done_a;
    assign m_mis     = inst ? mis_b     : mis_a;
    assign m_busy    = inst ? busy_b    : busy_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},    64'(m_busy),    64'd0);
        chk({tag, "_req"},     64'(m_req),     64'd0);
        chk({tag, "_dat"},     m_dat,          64'd0);
        chk({tag, "_sel"},     m_sel,          64'd0);
        chk({tag, "_q"},       m_q,            64'd0);
        chk({tag, "_done"},    64'(m_done),    64'd0);
        chk({tag, "_shdone"},  64'(m_sh_done), 64'd0);
        chk({tag, "_mis"},     64'(m_mis),     64'd0);
    endtask

    function automatic int xl();
        return inst ? 64 : 32;
    endfunction

    function automatic int bp();
        return inst ? 4 : 1;
    endfunction

    function automatic logic [63:0] xmask();
        return inst ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic bit gap();
        if (gap_mode == 1) begin
            gap_tog = ~gap_tog;
            return gap_tog;
        end
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic logic [63:0] exp_store_dat(input logic [63:0] v, input int l);
        logic [127:0] t;
        t = {64'd0, v} << (8 * l);
        return t[63:0] & xmask();
    endfunction

    function automatic logic [63:0] exp_sel(input int s, input int l);
        int nb, bytes;
        logic [127:0] m;
        nb = xl() / 8;
        bytes = 1 << s;
        if (bytes > nb) bytes = nb;
        m = ((128'd1 << bytes) - 128'd1) << l;
        return m[63:0] & ((64'd1 << nb) - 64'd1);
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] r, input int l, input int s, input bit sg);
        logic [127:0] sh, keep;
        int kw;
        sh = {64'd0, r & xmask()} >> (8 * l);
        kw = 8 << s;
        if (kw > xl()) kw = xl();
        keep = (128'd1 << kw) - 128'd1;
        sh = sh & keep;
        if (sg && sh[kw-1]) sh = sh | ({64'd0, xmask()} & ~keep);
        return sh[63:0];
    endfunction

    task automatic start_op(input logic [1:0] m, input int l, input int s, input bit sg);
        @(negedge clk);
        mode = m; lsb = 3'(l); size = 2'(s); sgn = sg; en = 1'b0;
        if (inst) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        #1 chk("busy_after_start", 64'(m_busy), 64'd1);
    endtask

    // Shift v in LSB-first over the serial port; checks o_op_b every beat and the end-of-fill pulses.
    task automatic fill(input logic [63:0] v, input bit exp_trap);
        int n, k;
        logic [3:0] beat;
        n = xl() / bp();
        k = 0;
        while (k < n) begin
            @(negedge clk);
            if (gap()) begin
                en = 1'b0;
            end else begin
                beat = 4'((v >> (k * bp())) & ((64'd1 << bp()) - 64'd1));
                en = 1'b1;
                op_b_sel = 1'($urandom);
                rs2 = op_b_sel ? beat : 4'($urandom);
                imm = op_b_sel ? 4'($urandom) : beat;
                #1 chk("fill_op_b", m_op_b, 64'(beat));
                chk("fill_req", 64'(m_req), 64'd0);
                if (k == n - 1) begin
                    chk("fill_end_done", 64'(m_done), 64'(exp_trap));
                    chk("fill_end_misalign", 64'(m_mis), 64'(exp_trap));
                end
                k++;
            end
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic do_store(input logic [63:0] v, input int l, input int s);
        bit trap;
        int w;
        logic [63:0] vv, ed;
        trap = TRAP && ((l % (1 << s)) != 0);
        vv = v & xmask();
        ed = exp_store_dat(vv, l);
        start_op(($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, l, s, 1'($urandom));
        fill(vv, trap);
        #1;
        if (trap) begin
            chk_idle("st_trap");
            return;
        end
        chk("st_req", 64'(m_req), 64'd1);
        chk("st_dat", m_dat, ed);
        chk("st_sel", m_sel, exp_sel(s, l));
        chk("st_done_early", 64'(m_done), 64'd0);
        w = $urandom_range(0, 2);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            mode = 2'd2;
            if (inst) start_b = 1'b1; else start_a = 1'b1;
            #1 chk("st_hold_req", 64'(m_req), 64'd1);
            chk("st_hold_dat", m_dat, ed);
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; ack = 1'b1;
        #1 chk("st_done", 64'(m_done), 64'd1);
        @(negedge clk);
        ack = 1'b0;
        #1 chk_idle("st_end");
    endtask

    task automatic do_load(input int l, input int s, input bit sg, input logic [63:0] r);
        bit trap;
        int n, k;
        logic [63:0] ev;
        trap = TRAP && ((l % (1 << s)) != 0);
        ev = exp_load(r, l, s, sg);
        n = xl() / bp();
        start_op(2'd1, l, s, sg);
        fill({$urandom, $urandom}, trap);
        #1;
        if (trap) begin
            chk_idle("ld_trap");
            return;
        end
        chk("ld_req", 64'(m_req), 64'd1);
        chk("ld_dat_zero", m_dat, 64'd0);
        ack = 1'b1; rdt = r;
        #1 chk("ld_done_early", 64'(m_done), 64'd0);
        @(negedge clk);
        ack = 1'b0; rdt = {$urandom, $urandom};
        k = 0;
        while (k < n) begin
            @(negedge clk);
            if (gap()) begin
                en = 1'b0;
            end else begin
                en = 1'b1;
                #1 chk("ld_q", m_q, (ev >> (k * bp())) & ((64'd1 << bp()) - 64'd1));
                chk("ld_done", 64'(m_done), 64'(k == n - 1));
                k++;
            end
        end
        @(negedge clk);
        en = 1'b0;
        #1 chk_idle("ld_end");
    endtask

    task automatic do_shift(input logic [63:0] v);
        int shamt, cyc;
        bit hit;
        shamt = int'(v & 64'(xl() - 1));
        start_op(2'd2, 0, 0, 1'b0);
        fill(v, 1'b0);
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 80) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            en = 1'($urandom);
            #1 hit = m_sh_done;
        end
        chk("sh_latency", 64'(cyc), 64'(shamt / bp() + 1));
        chk("sh_rem", m_sh_rem, 64'(shamt % bp()));
        chk("sh_done", 64'(m_done), 64'd1);
        @(negedge clk);
        en = 1'b0;
        #1 chk_idle("sh_end");
    endtask

    initial begin
        int op;
        #1;
        inst = 1'b0;
        #1 chk_idle("reset_a");
        inst = 1'b1;
        #1 chk_idle("reset_b");
        @(negedge clk);
        rst = 1'b0;

        inst = 1'b0;
        do_store(64'hDEAD_BEEF, 0, 2);
        do_store(64'h0000_00A5, 2, 0);
        do_load(3, 0, 1'b1, 64'h8011_2233);
        do_store(64'h1234_5678, 2, 2);

        inst = 1'b1;
        do_shift(64'd13);
        do_shift(64'd0);
        do_shift(64'd63);
        gap_mode = 1;
        do_load(0, 3, 1'b0, {$urandom, $urandom});
        gap_mode = 0;

`ifdef SERV_BUFREG_MISALIGN_TRAP_EN
        inst = 1'b0;
        do_store(64'h0000_BEEF, 1, 1);
`endif

        inst = 1'b0;
        start_op(2'd0, 0, 2, 1'b0);
        fill(64'h0F0F_0F0F, 1'b0);
        #1 chk("rst_wait_req", 64'(m_req), 64'd1);
        rst = 1'b1;
        #1 chk("rst_mid_req", 64'(m_req), 64'd0);
        chk("rst_mid_busy", 64'(m_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            inst = 1'($urandom);
            op = $urandom_range(0, 2);
            if (op == 0)
                do_store({$urandom, $urandom}, $urandom_range(0, inst ? 7 : 3), $urandom_range(0, inst ? 3 : 2));
            else if (op == 1)
                do_load($urandom_range(0, inst ? 7 : 3), $urandom_range(0, inst ? 3 : 2), 1'($urandom), {$urandom, $urandom});
            else
                do_shift({$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serv_bufreg3.md
Name: serv_bufreg3

Overview:
- Parametrised successor to the bit-serial buffer register of the SERV core.
- Owns one XLEN-wide data register that serves three roles:
  - store-data aligner with byte-select generation;
  - load-data capture, align and sign-extend, serialiser to rd;
  - shift-amount downcounter.
- Adds XLEN=64 support, an explicit FSM with a bus handshake, size/sign handling, and a remainder-aware shift counter for any BITS_PER_CYCLE.
- Sits between the serial datapath (rs2/imm in, rd out) and the data bus.

Parameters:
- XLEN, 32, data width; 32 or 64.
- BITS_PER_CYCLE, 1, serial datapath width; 1, 2, 4 or 8.
- LB, $clog2(BITS_PER_CYCLE), width of the remainder field minus one.
- SHW, $clog2(XLEN), shift-amount width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_start  in  1  begin operation; sampled in IDLE only.
- i_mode  in  2  0 = store, 1 = load, 2 = shift; 3 is reserved and treated as store.
- i_en  in  1  serial beat enable for FILL and DRAIN.
- i_op_b_sel  in  1  1 = rs2, 0 = imm.
- i_rs2  in  BITS_PER_CYCLE  serial rs2 bits.
- i_imm  in  BITS_PER_CYCLE  serial immediate bits.
- i_lsb  in  SHW-3  byte offset.
- i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (double valid only when XLEN=64).
- i_signed  in  1  sign-extend load.
- i_ack  in  1  bus acknowledge.
- i_rdt  in  XLEN  bus read data.
- o_op_b  out  BITS_PER_CYCLE  equals i_op_b_sel ? i_rs2 : i_imm (combinational).
- o_req  out  1  bus request.
- o_dat  out  XLEN  bus write data.
- o_sel  out  XLEN/8  byte selects.
- o_q  out  BITS_PER_CYCLE  serial load data.
- o_sh_done  out  1  one-cycle pulse: shift count exhausted.
- o_sh_rem  out  LB+1  residual shift amount, valid with o_sh_done.
- o_done  out  1  one-cycle completion pulse.
- o_misalign  out  1  one-cycle misalignment pulse.
- o_busy  out  1  high when state is not IDLE.

Behaviour:
- States: IDLE, FILL, WAIT, COUNT, DRAIN.
- Reset: state=IDLE, dat=0, beat counter=0. All outputs 0 except o_op_b.
- IDLE:
  - i_start latches mode, lsb, size and signed, clears the beat counter, and moves to FILL next cycle.
  - i_start in any other state is ignored.
- FILL:
  - On each i_en cycle: dat <= {o_op_b, dat[XLEN-1:BITS_PER_CYCLE]}; beat counter increments.
  - After N = XLEN/BITS_PER_CYCLE beats:
    - store or load → WAIT;
    - shift → COUNT, with counter c = dat[SHW-1:0] (the final dat value).
  - i_en low stalls FILL with no state change.
- WAIT:
  - o_req=1.
  - Store: o_dat = dat << 8*lsb (bits shifted past bit XLEN-1 are discarded); o_sel = mask(size) << lsb, truncated to XLEN/8 bits.
  - mask(size): byte 0x1, half 0x3, word 0xF, double all ones.
  - On i_ack:
    - store → IDLE with o_done pulse;
    - load → dat <= ext(i_rdt >> 8*lsb) and move to DRAIN.
  - ext(): keep the low 8, 16, 32 or 64 bits per size; upper bits are a copy of the top kept bit if signed, else 0.
  - No timeout; the block waits indefinitely for i_ack.
- DRAIN:
  - o_q = dat[BITS_PER_CYCLE-1:0].
  - On each i_en cycle: dat shifts right by BITS_PER_CYCLE and the beat counter increments.
  - After N beats → IDLE with o_done pulse. i_en low stalls.
- COUNT (independent of i_en):
  - If c >= BITS_PER_CYCLE: c <= c - BITS_PER_CYCLE.
  - Else: o_sh_done=1, o_sh_rem=c, o_done=1, → IDLE.
  - shamt=0 completes in the first COUNT cycle with rem 0.
  - Latency = floor(shamt/BITS_PER_CYCLE)+1 cycles.
- i_rst asserted mid-operation aborts immediately to the reset state; o_req drops asynchronously.
- o_dat, o_sel and o_q are 0 outside WAIT (store) and DRAIN respectively.

Optional Feature:
- Macro: SERV_BUFREG_MISALIGN_TRAP_EN.
- Defined: at the end of FILL for load/store, the access is misaligned when (lsb mod bytes(size)) != 0. A misaligned access skips WAIT and returns to IDLE with o_misalign=1 and o_done=1 together for one cycle; no o_req is issued.
- Undefined: o_misalign is tied to 0 and every access proceeds, with o_sel truncated as above.

Test Plan:
- XLEN=32, BPC=1, store word 0xDEADBEEF, lsb=0 → after 32 FILL beats o_req=1, o_dat=0xDEADBEEF, o_sel=0xF; i_ack → o_done pulse, IDLE.
- Store byte 0x000000A5, lsb=2 → o_dat=0x00A50000, o_sel=0x4.
- Load byte signed, lsb=3, i_rdt=0x80112233 → o_q serialises 0xFFFFFF80 LSB-first over 32 beats, then o_done.
- BPC=4, shift with shamt=13 → o_sh_done on the 4th COUNT cycle, o_sh_rem=1; shamt=0 → done in the first cycle, rem=0.
- XLEN=64, load double unsigned, lsb=0, with i_en toggling every other cycle → beat count stays correct, 64-bit value reproduced exactly.
- With SERV_BUFREG_MISALIGN_TRAP_EN: half store at lsb=1 → o_misalign=1, o_done=1, o_req never asserted. i_rst pulsed mid-WAIT → o_req=0, o_busy=0 immediately.
